rx_burst: RTL and testbench
===========================

Name: rx_burst

Overview:
- Receive-side counterpart of the GMSK burst transmitter.
- Watches RF-chain I/Q samples for a burst's power envelope (ramp-up → full power → ramp-down) and gates the demodulator's symbol stream into a burst window.
- Checks received symbols against the transmitter's 8-bit PRBS and reports per-burst bit errors, peak magnitude and truncation.
- Sits between the RX RF front end / GMSK demodulator and the link-test control logic.

Parameters:
IQ_BITS, 9, signed I/Q sample width (matches TX rfchain output)
MAG_THRESH, 10'd64, |I|+|Q| level counted as "energy present"
HOLDOFF_SAMPLES, 16, consecutive above-threshold samples needed to declare burst start (max 255)
QUIET_SAMPLES, 64, consecutive below-threshold samples needed to declare burst end (max 255)
SYMS_PER_BURST, 17, payload symbols checked per burst (max 255)
LFSR_TAPS, 8'h8e, Galois PRBS taps
LFSR_SEED, 8'h01, PRBS state at start of each burst

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low
iq_valid  in  1  sample strobe; I/Q below are valid this cycle
rx_inphase  in  IQ_BITS  signed I sample
rx_quadrature  in  IQ_BITS  signed Q sample
demod_symbol_strobe  in  1  one-cycle pulse: demod_symbol valid
demod_symbol  in  1  demodulated hard bit
rx_symbol  out  1  symbol forwarded during the burst window
rx_symbol_valid  out  1  one-cycle pulse with rx_symbol
in_burst  out  1  high while the burst window is open
burst_done  out  1  one-cycle pulse; report outputs valid from this cycle on
bit_errors  out  8  mismatches in the last burst, saturating at 255
peak_mag  out  IQ_BITS+1  max |I|+|Q| seen in the last burst window
truncated  out  1  last burst ended before SYMS_PER_BURST symbols arrived

Behaviour:
- Reset: values apply on the first clock edge with reset==0 (synchronous, active-low).
  - All outputs 0; state IDLE; counters 0; lfsr = LFSR_SEED.
  - Reset mid-burst abandons the burst without a burst_done pulse.
- Magnitude:
  - mag = |I| + |Q|, IQ_BITS+1 bits unsigned, registered: 1-cycle pipeline stage, sampled only on iq_valid.
  - |−256| = 256; no overflow possible.
  - above = (mag >= MAG_THRESH).
- Run counters: 8-bit run counter counts consecutive above (or below) samples, reset on polarity change. Samples without iq_valid neither count nor break a run.
- States:
  - IDLE: lfsr = LFSR_SEED, sym_cnt = 0, err = 0, peak = 0.
    - above → ARM with run = 1.
  - ARM:
    - Each above sample increments run.
    - A below sample → IDLE.
    - Reaching HOLDOFF_SAMPLES → ACTIVE; in_burst = 1 from the next cycle.
    - Symbol strobes in IDLE/ARM are ignored.
  - ACTIVE:
    - On demod_symbol_strobe:
      - rx_symbol <= demod_symbol; rx_symbol_valid pulses next cycle.
      - If demod_symbol != lfsr[1], err increments (sat 255).
      - lfsr steps: lfsr = {0, lfsr[7:1]}, XOR LFSR_TAPS if the old lfsr[0] == 1.
      - sym_cnt increments.
    - sym_cnt reaching SYMS_PER_BURST → TAIL; the triggering symbol is included.
    - QUIET_SAMPLES consecutive below samples → REPORT with truncated = 1.
    - peak = max(peak, mag) on every valid sample.
  - TAIL:
    - in_burst = 0; symbols ignored.
    - Wait QUIET_SAMPLES consecutive below samples (run counter is not reset on entry) → REPORT with truncated = 0.
  - REPORT (1 cycle):
    - burst_done = 1.
    - bit_errors, peak_mag, truncated latched and held until the next REPORT.
    - → IDLE.
- Simultaneous events:
  - A symbol strobe on the same cycle as the quiet-run completion in ACTIVE is counted first, then truncation is evaluated on the updated sym_cnt. If that makes sym_cnt == SYMS_PER_BURST, the burst is not truncated and goes directly to REPORT.
  - The cycle ACTIVE is entered also accepts a symbol strobe.
- Wrap-around: all counters saturate; none wraps.

Decomposition:
- Shared package (rx/tx common): PRBS taps/seed constants, IQ sample width, state encoding (one-hot 5-bit, matching TX burst style).
- TX and RX must import the same LFSR constants.
- One natural sub-module: prbs_lfsr8 (step-enable, synchronous load-seed, exposes state). Reusable by TX; RX instantiates it once.
- Everything else stays in rx_burst.

Test Plan:
1. TX loopback: tx_burst I/Q fed into rx_burst, demod replaced by TX symbol stream (ideal) → one burst_done, bit_errors=0, truncated=0, peak_mag=256 for full-scale ±255/±1 samples (|I|+|Q| peak ≥ 250).
2. Sub-holdoff glitch: 15 samples at I=100,Q=0 then 100 samples at 0 → stays IDLE, no in_burst, no burst_done.
3. Error injection: ideal burst with demod_symbol inverted on symbols 3 and 10 → bit_errors=2; with all 17 inverted → 17.
4. Early dropout: energy stops after 9 symbols for ≥64 samples → burst_done, truncated=1, bit_errors=0.
5. Back-to-back: two bursts separated by 64 quiet samples → two burst_done pulses, second bit_errors=0, showing LFSR reseeds to 8'h01.
6. Reset mid-ACTIVE after 5 symbols → all outputs 0 next cycle, no burst_done; next clean burst reports bit_errors=0.

Source files
------------

// File: rtl/rx_burst_pkg.sv
// Shared RX/TX burst package.
// Holds the I/Q sample width, the PRBS constants both ends must agree on,
// the one-hot burst state encoding and small arithmetic helpers.
package rx_burst_pkg;

  // Signed I/Q sample width produced by the TX RF chain.
  localparam int IQ_BITS  = 9;
  // |I|+|Q| needs one extra bit: the largest sum is 256 + 256 = 512.
  localparam int MAG_BITS = IQ_BITS + 1;

  // Galois PRBS shared by transmitter and receiver.
  localparam logic [7:0] LFSR_TAPS = 8'h8e;
  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Bit of the PRBS state that carries the reference symbol.
  localparam logic [7:0] PRBS_OUT_MASK = 8'h02;

  // One-hot burst states, same style as the TX burst sequencer.
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_ARM    = 5'b00010,
    ST_ACTIVE = 5'b00100,
    ST_TAIL   = 5'b01000,
    ST_REPORT = 5'b10000
  } burst_state_t;

  // Absolute value of a signed sample, widened so that |-256| = 256 fits.
  function automatic logic [MAG_BITS-1:0] abs_iq(input logic signed [IQ_BITS-1:0] v);
    logic signed [MAG_BITS-1:0] ext;
    ext = {v[IQ_BITS-1], v};
    return ext[MAG_BITS-1] ? MAG_BITS'(-ext) : MAG_BITS'(ext);
  endfunction

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/prbs_lfsr8.sv
// 8-bit Galois PRBS generator shared by the burst transmitter and receiver.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-low; loads LFSR_SEED
//   load   - synchronous reload of LFSR_SEED (wins over step)
//   step   - advance one PRBS step
//   state  - current LFSR state
module prbs_lfsr8
  import rx_burst_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  output logic [7:0] state
);

  // NOTE: sequential state is only ever assigned with <= so every flop
  // samples the pre-edge values of its neighbours; reset is synchronous.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= LFSR_SEED;
    end else if (load) begin
      state <= LFSR_SEED;
    end else if (step) begin
      // Shift right; fold the taps back in when a 1 falls out of bit 0.
      state <= {1'b0, state[7:1]} ^ (state[0] ? LFSR_TAPS : 8'h00);
    end
  end

endmodule

// File: rtl/rx_burst.sv
// Receive-side burst detector and PRBS checker.
// Detects a burst from the |I|+|Q| power envelope, opens a symbol window,
// compares demodulated symbols with the shared PRBS and reports the
// per-burst error count, peak magnitude and truncation.
// Ports:
//   clock, reset         - system clock; synchronous active-low reset
//   iq_valid             - rx_inphase / rx_quadrature valid this cycle
//   rx_inphase           - signed I sample
//   rx_quadrature        - signed Q sample
//   demod_symbol_strobe  - demod_symbol valid this cycle
//   demod_symbol         - demodulated hard bit
//   rx_symbol            - symbol forwarded inside the burst window
//   rx_symbol_valid      - one-cycle pulse with rx_symbol
//   in_burst             - burst window open
//   burst_done           - one-cycle pulse; report outputs valid from here on
//   bit_errors           - PRBS mismatches in the last burst (saturating)
//   peak_mag             - largest |I|+|Q| inside the last burst window
//   truncated            - last burst ended before all payload symbols arrived
module rx_burst
  import rx_burst_pkg::*;
#(
  parameter logic [MAG_BITS-1:0] MAG_THRESH      = 10'd64,
  parameter int                  HOLDOFF_SAMPLES = 16,
  parameter int                  QUIET_SAMPLES   = 64,
  parameter int                  SYMS_PER_BURST  = 17
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iq_valid,
  input  logic signed [IQ_BITS-1:0]  rx_inphase,
  input  logic signed [IQ_BITS-1:0]  rx_quadrature,
  input  logic                       demod_symbol_strobe,
  input  logic                       demod_symbol,
  output logic                       rx_symbol,
  output logic                       rx_symbol_valid,
  output logic                       in_burst,
  output logic                       burst_done,
  output logic [7:0]                 bit_errors,
  output logic [MAG_BITS-1:0]        peak_mag,
  output logic                       truncated
);

  localparam logic [7:0] HOLDOFF_CNT = 8'(HOLDOFF_SAMPLES);
  localparam logic [7:0] QUIET_CNT   = 8'(QUIET_SAMPLES);
  localparam logic [7:0] SYMS_CNT    = 8'(SYMS_PER_BURST);

  // Magnitude pipeline stage: one register, updated only on valid samples.
  logic [MAG_BITS-1:0] mag;
  logic                mag_valid;
  logic                above;

  always_ff @(posedge clock) begin
    if (!reset) begin
      mag       <= '0;
      mag_valid <= 1'b0;
    end else begin
      mag_valid <= iq_valid;
      if (iq_valid) begin
        mag <= abs_iq(rx_inphase) + abs_iq(rx_quadrature);
      end
    end
  end

  assign above = (mag >= MAG_THRESH);

  // Burst bookkeeping.
  burst_state_t        state;
  logic [7:0]          run_cnt;
  logic                run_above;
  logic [7:0]          sym_cnt;
  logic [7:0]          err_cnt;
  logic [MAG_BITS-1:0] peak;
  logic [7:0]          lfsr_state;

  // Next-value helpers for the FSM.
  logic [7:0]          run_next;
  logic                run_above_next;
  logic                holdoff_done;
  logic                quiet_done;
  logic                enter_active;
  logic                sym_accept;
  logic                sym_miss;
  logic [7:0]          sym_next;
  logic [7:0]          err_next;
  logic [MAG_BITS-1:0] peak_next;
  logic                lfsr_load;

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    run_next       = run_cnt;
    run_above_next = run_above;
    if (mag_valid) begin
      run_above_next = above;
      // A polarity change restarts the run; IDLE always starts the
      // holdoff count afresh at 1.
      if ((above != run_above) || (state == ST_IDLE && above)) begin
        run_next = 8'd1;
      end else begin
        run_next = sat_inc8(run_cnt);
      end
    end

    holdoff_done = mag_valid && above && (run_next >= HOLDOFF_CNT);
    quiet_done   = mag_valid && !above && (run_next >= QUIET_CNT);
    enter_active = holdoff_done && (state == ST_IDLE || state == ST_ARM);

    // The cycle that opens the window already accepts a symbol.
    sym_accept = demod_symbol_strobe && (state == ST_ACTIVE || enter_active);
    sym_miss   = demod_symbol != (|(lfsr_state & PRBS_OUT_MASK));
    sym_next   = sym_accept ? sat_inc8(sym_cnt) : sym_cnt;
    err_next   = (sym_accept && sym_miss) ? sat_inc8(err_cnt) : err_cnt;

    peak_next = peak;
    if (state == ST_ACTIVE && mag_valid && mag > peak) begin
      peak_next = mag;
    end

    lfsr_load = (state == ST_IDLE) || (state == ST_REPORT);
  end

  prbs_lfsr8 u_prbs (
    .clock (clock),
    .reset (reset),
    .load  (lfsr_load),
    .step  (sym_accept),
    .state (lfsr_state)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= ST_IDLE;
      run_cnt         <= '0;
      run_above       <= 1'b0;
      sym_cnt         <= '0;
      err_cnt         <= '0;
      peak            <= '0;
      rx_symbol       <= 1'b0;
      rx_symbol_valid <= 1'b0;
      in_burst        <= 1'b0;
      burst_done      <= 1'b0;
      bit_errors      <= '0;
      peak_mag        <= '0;
      truncated       <= 1'b0;
    end else begin
      run_cnt         <= run_next;
      run_above       <= run_above_next;
      rx_symbol_valid <= sym_accept;
      burst_done      <= 1'b0;
      if (sym_accept) begin
        rx_symbol <= demod_symbol;
      end

      case (state)
        ST_IDLE, ST_ARM: begin
          if (enter_active) begin
            state    <= ST_ACTIVE;
            in_burst <= 1'b1;
            sym_cnt  <= sym_next;
            err_cnt  <= err_next;
          end else if (mag_valid && above) begin
            state <= ST_ARM;
          end else if (mag_valid) begin
            state <= ST_IDLE;
          end
        end

        ST_ACTIVE: begin
          sym_cnt <= sym_next;
          err_cnt <= err_next;
          peak    <= peak_next;
          // A symbol landing on the quiet-run completion counts before the
          // truncation decision, and a complete burst then reports directly.
          if (quiet_done) begin
            state      <= ST_REPORT;
            in_burst   <= 1'b0;
            burst_done <= 1'b1;
            bit_errors <= err_next;
            peak_mag   <= peak_next;
            truncated  <= (sym_next < SYMS_CNT);
          end else if (sym_next >= SYMS_CNT) begin
            state    <= ST_TAIL;
            in_burst <= 1'b0;
          end
        end

        ST_TAIL: begin
          // The quiet run started in ACTIVE carries over into TAIL.
          if (quiet_done) begin
            state      <= ST_REPORT;
            burst_done <= 1'b1;
            bit_errors <= err_cnt;
            peak_mag   <= peak;
            truncated  <= 1'b0;
          end
        end

        ST_REPORT: begin
          // Clear here so a burst starting straight out of IDLE sees zeros.
          state   <= ST_IDLE;
          sym_cnt <= '0;
          err_cnt <= '0;
          peak    <= '0;
        end

        default: begin
          state    <= ST_IDLE;
          in_burst <= 1'b0;
          sym_cnt  <= '0;
          err_cnt  <= '0;
          peak     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_burst.sv
// Self-checking bench for rx_burst. Bursts are built from a high-level
// description (holdoff length, payload symbols, injected errors, quiet tail)
// and the expected report is computed arithmetically from that description.
module tb_rx_burst;
  import rx_burst_pkg::*;

  typedef enum {M_FULL, M_TRUNC, M_LATE} burst_mode_t;

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic                      iq_valid = 1'b0;
  logic signed [IQ_BITS-1:0] rx_inphase = '0;
  logic signed [IQ_BITS-1:0] rx_quadrature = '0;
  logic                      demod_symbol_strobe = 1'b0;
  logic                      demod_symbol = 1'b0;
  logic                      rx_symbol;
  logic                      rx_symbol_valid;
  logic                      in_burst;
  logic                      burst_done;
  logic [7:0]                bit_errors;
  logic [MAG_BITS-1:0]       peak_mag;
  logic                      truncated;

  int tests_run    = 0;
  int tests_failed = 0;

  // Event counters written only by the monitor.
  int   done_cnt = 0;
  int   valid_cnt = 0;
  int   in_burst_cycles = 0;
  logic sym_hist [4096];

  // Expected PRBS symbol sequence from the seed.
  logic prbs_ref [32];

  rx_burst dut (
    .clock               (clock),
    .reset               (reset),
    .iq_valid            (iq_valid),
    .rx_inphase          (rx_inphase),
    .rx_quadrature       (rx_quadrature),
    .demod_symbol_strobe (demod_symbol_strobe),
    .demod_symbol        (demod_symbol),
    .rx_symbol           (rx_symbol),
    .rx_symbol_valid     (rx_symbol_valid),
    .in_burst            (in_burst),
    .burst_done          (burst_done),
    .bit_errors          (bit_errors),
    .peak_mag            (peak_mag),
    .truncated           (truncated)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset) begin
      if (burst_done) done_cnt++;
      if (in_burst) in_burst_cycles++;
      if (rx_symbol_valid) begin
        sym_hist[valid_cnt % 4096] = rx_symbol;
        valid_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // One clock of stimulus; inputs change 1 time unit after the active edge.
  task automatic drive(input logic v, input int i, input int q, input logic stb, input logic b);
    iq_valid            = v;
    rx_inphase          = IQ_BITS'(i);
    rx_quadrature       = IQ_BITS'(q);
    demod_symbol_strobe = stb;
    demod_symbol        = b;
    @(posedge clock);
    #1;
    iq_valid            = 1'b0;
    demod_symbol_strobe = 1'b0;
  endtask

  // Cycle without a sample; junk on I/Q must be ignored.
  task automatic idle();
    drive(1'b0, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256, 1'b0, 1'b0);
  endtask

  task automatic pick_iq(input bit want_above, output int i, output int q);
    int a, b;
    if (want_above) begin
      case ($urandom_range(0, 9))
        0: begin i = 64;   q = 0;    end
        1: begin i = -256; q = -256; end
        2: begin i = -40;  q = 24;   end
        default: begin
          do begin
            i = int'($urandom_range(0, 511)) - 256;
            q = int'($urandom_range(0, 511)) - 256;
          end while (iabs(i) + iabs(q) < 64);
        end
      endcase
    end else begin
      a = int'($urandom_range(0, 63));
      b = int'($urandom_range(0, 63 - a));
      if ($urandom_range(0, 5) == 0) begin a = 40; b = 23; end
      i = $urandom_range(0, 1) ? -a : a;
      q = $urandom_range(0, 1) ? -b : b;
    end
  endtask

  // Optional gap cycles, then one valid sample; returns its magnitude.
  task automatic send_sample(input bit want_above, input logic stb, input logic b, output int m);
    int i, q;
    repeat ($urandom_range(0, 2)) idle();
    pick_iq(want_above, i, q);
    m = iabs(i) + iabs(q);
    drive(1'b1, i, q, stb, b);
  endtask

  // Sub-holdoff energy followed by silence: nothing may happen.
  task automatic run_glitch(input string name, input int len, input bit directed, input int quiet);
    int m, done_base, valid_base, inb_base;
    done_base  = done_cnt;
    valid_base = valid_cnt;
    inb_base   = in_burst_cycles;
    for (int k = 0; k < len; k++) begin
      if (directed) drive(1'b1, 100, 0, 1'(k % 3 == 0), 1'b1);
      else send_sample(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m);
    end
    for (int k = 0; k < quiet; k++) begin
      if (directed) drive(1'b1, 0, 0, 1'b0, 1'b0);
      else send_sample(1'b0, 1'b0, 1'b0, m);
    end
    repeat (2) idle();
    check({name, ".no_in_burst"}, in_burst_cycles - inb_base, 0);
    check({name, ".no_done"}, done_cnt - done_base, 0);
    check({name, ".no_symbols"}, valid_cnt - valid_base, 0);
  endtask

  // Holdoff plus the first nsym payload symbols; returns peak and errors so far.
  task automatic open_burst(input string name, input int nsym, input logic [16:0] inj,
                            output int exp_peak, output int exp_err, output int mism_base);
    int m;
    logic b;
    exp_peak  = 0;
    exp_err   = 0;
    mism_base = valid_cnt;
    // Strobes during holdoff must be ignored.
    for (int k = 0; k < 16; k++) begin
      send_sample(1'b1, 1'((k < 15) && ($urandom_range(0, 1) == 1)), 1'($urandom_range(0, 1)), m);
    end
    repeat (3) idle();
    check({name, ".in_burst_open"}, in_burst, 1);
    check({name, ".no_early_symbols"}, valid_cnt - mism_base, 0);
    for (int k = 0; k < nsym; k++) begin
      repeat ($urandom_range(1, 3)) begin
        send_sample(1'b1, 1'b0, 1'b0, m);
        if (m > exp_peak) exp_peak = m;
      end
      b = prbs_ref[k] ^ inj[k];
      if (inj[k]) exp_err++;
      drive(1'b0, 0, 0, 1'b1, b);
    end
  endtask

  // Compares forwarded symbols against PRBS ^ injected errors.
  task automatic check_symbols(input string name, input int base, input int nsym, input logic [16:0] inj);
    int bad;
    bad = 0;
    for (int k = 0; k < nsym; k++) begin
      if (sym_hist[(base + k) % 4096] !== (prbs_ref[k] ^ inj[k])) bad++;
    end
    check({name, ".symbol_count"}, valid_cnt - base, nsym);
    check({name, ".symbol_values_bad"}, bad, 0);
  endtask

  task automatic run_burst(input string name, input burst_mode_t mode, input int nsym, input logic [16:0] inj);
    int   m, exp_peak, exp_err, base, done_base, pre_quiet, quiet_left, n_first, n_total;
    logic exp_trunc;
    logic b;
    done_base = done_cnt;
    n_first   = (mode == M_TRUNC) ? nsym : 16;
    n_total   = (mode == M_TRUNC) ? nsym : 17;
    exp_trunc = (mode == M_TRUNC);
    open_burst(name, n_first, inj, exp_peak, exp_err, base);
    quiet_left = 64;

    if (mode == M_FULL) begin
      // Some quiet before the last symbol; the run must carry into TAIL.
      repeat ($urandom_range(1, 3)) begin
        send_sample(1'b1, 1'b0, 1'b0, m);
        if (m > exp_peak) exp_peak = m;
      end
      pre_quiet = int'($urandom_range(0, 20));
      for (int k = 0; k < pre_quiet; k++) send_sample(1'b0, 1'b0, 1'b0, m);
      quiet_left = 64 - pre_quiet;
      b = prbs_ref[16] ^ inj[16];
      if (inj[16]) exp_err++;
      drive(1'b0, 0, 0, 1'b1, b);
      check({name, ".in_burst_closes"}, in_burst, 0);
    end

    for (int k = 0; k < quiet_left; k++) begin
      if (k == quiet_left - 1) check({name, ".no_early_done"}, done_cnt - done_base, 0);
      // Strobes in TAIL are ignored; in ACTIVE they would count, so only FULL sends them.
      send_sample(1'b0, 1'((mode == M_FULL) && ($urandom_range(0, 3) == 0)), 1'b1, m);
    end

    if (mode == M_LATE) begin
      // Last symbol on the same cycle the quiet run completes.
      b = prbs_ref[16] ^ inj[16];
      if (inj[16]) exp_err++;
      drive(1'b0, 0, 0, 1'b1, b);
    end else begin
      idle();
    end

    check({name, ".burst_done"}, burst_done, 1);
    check({name, ".bit_errors"}, bit_errors, exp_err);
    check({name, ".peak_mag"}, peak_mag, exp_peak);
    check({name, ".truncated"}, truncated, exp_trunc);
    check({name, ".in_burst_after"}, in_burst, 0);
    idle();
    check({name, ".done_one_cycle"}, burst_done, 0);
    check({name, ".done_count"}, done_cnt - done_base, 1);
    check({name, ".report_held"}, bit_errors, exp_err);
    check_symbols(name, base, n_total, inj);
    repeat (2) idle();
  endtask

  initial begin
    logic [7:0]  lfsr;
    logic [16:0] inj;
    int          pe, ee, base, done_base;

    lfsr = 8'h01;
    for (int k = 0; k < 32; k++) begin
      prbs_ref[k] = lfsr[1];
      lfsr = (lfsr >> 1) ^ (lfsr[0] ? 8'h8e : 8'h00);
    end

    // Reset state.
    reset = 1'b0;
    repeat (3) idle();
    check("reset.rx_symbol", rx_symbol, 0);
    check("reset.rx_symbol_valid", rx_symbol_valid, 0);
    check("reset.in_burst", in_burst, 0);
    check("reset.burst_done", burst_done, 0);
    check("reset.bit_errors", bit_errors, 0);
    check("reset.peak_mag", peak_mag, 0);
    check("reset.truncated", truncated, 0);
    reset = 1'b1;
    repeat (2) idle();

    run_glitch("glitch15", 15, 1'b1, 100);
    run_burst("clean", M_FULL, 17, 17'h0);
    run_burst("err_3_10", M_FULL, 17, 17'h00408);
    run_burst("err_all", M_FULL, 17, 17'h1ffff);
    run_burst("dropout9", M_TRUNC, 9, 17'h0);
    run_burst("late_last", M_LATE, 17, 17'h10001);
    run_burst("back_to_back", M_FULL, 17, 17'h0);

    for (int r = 0; r < 8; r++) begin
      inj = '0;
      for (int k = 0; k < 17; k++) inj[k] = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: run_glitch($sformatf("rnd%0d.glitch", r), int'($urandom_range(1, 15)), 1'b0,
                      int'($urandom_range(1, 20)));
        1: run_burst($sformatf("rnd%0d.full", r), M_FULL, 17, inj);
        2: run_burst($sformatf("rnd%0d.trunc", r), M_TRUNC, int'($urandom_range(1, 16)), inj);
        default: run_burst($sformatf("rnd%0d.late", r), M_LATE, 17, inj);
      endcase
    end

    // Reset in the middle of an active burst.
    done_base = done_cnt;
    open_burst("mid_reset", 5, 17'h0, pe, ee, base);
    reset = 1'b0;
    idle();
    check("mid_reset.in_burst", in_burst, 0);
    check("mid_reset.rx_symbol_valid", rx_symbol_valid, 0);
    check("mid_reset.bit_errors", bit_errors, 0);
    check("mid_reset.peak_mag", peak_mag, 0);
    check("mid_reset.truncated", truncated, 0);
    check("mid_reset.burst_done", burst_done, 0);
    reset = 1'b1;
    repeat (80) idle();
    check("mid_reset.no_done", done_cnt - done_base, 0);
    run_burst("after_reset", M_FULL, 17, 17'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
